demultiplexador_quadro: RTL

- Sequential 1-to-N demultiplexer: the inverse of the 2x1/Nx1 selection muxes used on the control datapath.
- Receives a time-multiplexed serial stream, one bit per slot, with slot 0 marked by `sync`.
- Routes slot i into output bit i through a shadow register.
- Updates all N outputs atomically at frame end, then raises a frame-complete strobe.
- Sits between the serial sensor/actuator link and the per-channel control logic.

---
 rtl/demultiplexador_quadro.sv | 121 ++++++++++++
 1 files changed

// File: rtl/demultiplexador_quadro.sv
// rtl/demultiplexador_quadro.sv - serial slot stream to N-bit parallel frame demultiplexer
//
// Purpose : collects one serial bit per valid slot (slot 0 marked by sync) into a
//           shadow register and publishes all N channels at once at frame end.
// Macro   : PARIDADE_EN - adds an even-parity slot N after the data slots; a
//           parity mismatch rejects the frame.
// Ports   : clk        rising-edge system clock
//           rst_n      asynchronous active-low reset
//           sync       marks slot 0 (only meaningful with din_valid)
//           din        serial data bit of the current slot
//           din_valid  din holds a valid slot this cycle
//           dout       [N-1:0] channel outputs, bit i = slot i of last good frame
//           frame_ok   one-cycle pulse, dout just updated
//           frame_err  one-cycle pulse, frame aborted or rejected
//           busy       a frame is partially received
//           slot       [W_CNT-1:0] index of the next slot expected
module demultiplexador_quadro #(
  parameter int N = 4,
`ifdef PARIDADE_EN
  localparam int W_CNT = $clog2(N + 1)
`else
  localparam int W_CNT = (N > 1) ? $clog2(N) : 1
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sync,
  input  logic             din,
  input  logic             din_valid,
  output logic [N-1:0]     dout,
  output logic             frame_ok,
  output logic             frame_err,
  output logic             busy,
  output logic [W_CNT-1:0] slot
);

`ifdef PARIDADE_EN
  typedef enum logic [1:0] {OCIOSO, RECEBENDO, CONCLUIDO, PARIDADE} estado_t;
`else
  typedef enum logic [1:0] {OCIOSO, RECEBENDO, CONCLUIDO} estado_t;
`endif

  estado_t      state;
  logic [N-1:0] shadow;
  logic         restart;    // sync qualified by din_valid: always starts a new frame
  logic         take_slot;  // ordinary data slot while receiving
  logic         last_slot;  // the slot accepted this edge is slot N-1

  always_comb begin
    restart   = din_valid && sync;
    take_slot = din_valid && !sync && (state == RECEBENDO);
    last_slot = restart ? (N == 1) : (slot == W_CNT'(N - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= OCIOSO;
      shadow    <= '0;
      dout      <= '0;
      slot      <= '0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;

      // CONCLUIDO lasts one cycle; the completed frame is published as it is left,
      // so a back-to-back slot 0 landing in shadow[0] on this edge is harmless.
      if (state == CONCLUIDO) begin
        dout     <= shadow;
        frame_ok <= 1'b1;
      end

      for (int i = 0; i < N; i++) begin
        if ((restart && i == 0) || (take_slot && slot == W_CNT'(i)))
          shadow[i] <= din;
      end

      if (restart || take_slot) begin
        // A sync while a frame is partially received throws that frame away.
        if (restart && busy)
          frame_err <= 1'b1;
        if (last_slot) begin
`ifdef PARIDADE_EN
          state <= PARIDADE;
          slot  <= W_CNT'(N);
          busy  <= 1'b1;
`else
          state <= CONCLUIDO;
          slot  <= '0;
          busy  <= 1'b0;
`endif
        end else begin
          state <= RECEBENDO;
          slot  <= restart ? W_CNT'(1) : slot + 1'b1;
          busy  <= 1'b1;
        end
      end
`ifdef PARIDADE_EN
      else if (state == PARIDADE) begin
        // sync here was already handled above as an abort/restart
        if (din_valid) begin
          slot <= '0;
          busy <= 1'b0;
          if ((^shadow) == din) begin
            state <= CONCLUIDO;
          end else begin
            state     <= OCIOSO;
            frame_err <= 1'b1;
          end
        end
      end
`endif
      else if (state == CONCLUIDO) begin
        state <= OCIOSO;
      end
    end
  end

endmodule
